// File: rtl/ret_addr_stack_if.sv
// Control-unit <-> return-address-stack signal bundle.
// The master side is the CALL/RET sequencer; the slave side is the stack.
interface ret_addr_stack_if #(
    parameter int AW    = 16,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          push;
    logic          pop;
    logic [AW-1:0] push_addr;
    logic          clr_err;
    logic [AW-1:0] top_addr;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, pop, push_addr, clr_err,
        input  top_addr, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, push_addr, clr_err,
        output top_addr, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/ret_addr_stack.sv
// Return-address LIFO feeding the PC load-data path; top_addr has zero pop latency.
// Define RAS_WRAP_EN for circular mode (push while full overwrites the oldest entry).
module ret_addr_stack #(
    parameter int AW    = 16,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic reset,
    ret_addr_stack_if.slave ras
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] SP_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] sp, sp_nxt, sp_m1, wr_idx;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ovf, unf;
    logic          ovf_set, unf_set, wr_en;
    logic          is_empty, is_full;

    assign sp_m1    = sp - SP_ONE;
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_FULL);

    assign ras.top_addr  = is_empty ? '0 : mem[sp_m1];
    assign ras.empty     = is_empty;
    assign ras.full      = is_full;
    assign ras.count     = cnt;
    assign ras.overflow  = ovf;
    assign ras.underflow = unf;

    always_comb begin
        sp_nxt  = sp;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_idx  = sp;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (ras.push && ras.pop) begin
            if (!is_empty) begin
                // tail call: replace the top frame in place
                wr_en  = 1'b1;
                wr_idx = sp_m1;
            end else begin
                wr_en   = 1'b1;
                sp_nxt  = sp + SP_ONE;
                cnt_nxt = cnt + CNT_ONE;
                unf_set = 1'b1;
            end
        end else if (ras.push) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                sp_nxt  = sp + SP_ONE;
                cnt_nxt = cnt + CNT_ONE;
            end else begin
                ovf_set = 1'b1;
`ifdef RAS_WRAP_EN
                wr_en  = 1'b1;
                sp_nxt = sp + SP_ONE;
`endif
            end
        end else if (ras.pop) begin
            if (!is_empty) begin
                sp_nxt  = sp_m1;
                cnt_nxt = cnt - CNT_ONE;
            end else begin
                unf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            sp  <= sp_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_set | (ovf & ~ras.clr_err);
            unf <= unf_set | (unf & ~ras.clr_err);
        end
    end

    // Storage is not reset; a reset-cycle write is harmless since count is cleared.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= ras.push_addr;
    end
endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed self-checking bench for ret_addr_stack (default and RAS_WRAP_EN builds).
module tb_ret_addr_stack;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    ret_addr_stack_if #(.AW(16), .DEPTH(8)) ras_if ();

    ret_addr_stack #(.AW(16), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .ras   (ras_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic p, input logic q, input logic [15:0] a, input logic c);
        ras_if.push      = p;
        ras_if.pop       = q;
        ras_if.push_addr = a;
        ras_if.clr_err   = c;
        @(posedge clk);
        #1;
        ras_if.push    = 1'b0;
        ras_if.pop     = 1'b0;
        ras_if.clr_err = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_top;
        ras_if.push = 0; ras_if.pop = 0; ras_if.push_addr = '0; ras_if.clr_err = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        check("rst_empty", ras_if.empty, 1);
        check("rst_full", ras_if.full, 0);
        check("rst_count", ras_if.count, 0);
        check("rst_top", ras_if.top_addr, 0);
        check("rst_ovf", ras_if.overflow, 0);
        check("rst_unf", ras_if.underflow, 0);

        // basic push/pop
        op(1, 0, 16'h0010, 0);
        op(1, 0, 16'h0020, 0);
        op(1, 0, 16'h0030, 0);
        check("t1_count", ras_if.count, 3);
        check("t1_top", ras_if.top_addr, 16'h0030);
        check("t1_empty", ras_if.empty, 0);
        op(0, 1, 16'h0, 0);
        check("t1_pop_top", ras_if.top_addr, 16'h0020);
        check("t1_pop_count", ras_if.count, 2);
        op(0, 1, 16'h0, 0);
        op(0, 1, 16'h0, 0);
        check("t1_drained", ras_if.empty, 1);

        // underflow and sticky clear
        op(0, 1, 16'h0, 0);
        check("t3_unf", ras_if.underflow, 1);
        check("t3_count", ras_if.count, 0);
        check("t3_top", ras_if.top_addr, 0);
        op(0, 0, 16'h0, 1);
        check("t3_clr", ras_if.underflow, 0);
        op(0, 1, 16'h0, 1);
        check("t3_set_wins", ras_if.underflow, 1);
        op(0, 0, 16'h0, 1);
        check("t3_clr2", ras_if.underflow, 0);

        // tail-call replace
        op(1, 0, 16'h0033, 0);
        op(1, 0, 16'h0044, 0);
        check("t4_top_before", ras_if.top_addr, 16'h0044);
        op(1, 1, 16'h0055, 0);
        check("t4_count", ras_if.count, 2);
        check("t4_top", ras_if.top_addr, 16'h0055);
        op(0, 1, 16'h0, 0);
        check("t4_prev", ras_if.top_addr, 16'h0033);
        check("t4_prev_count", ras_if.count, 1);
        op(0, 1, 16'h0, 0);

        // push+pop while empty acts as push and flags underflow
        op(1, 1, 16'h0066, 0);
        check("pp_empty_count", ras_if.count, 1);
        check("pp_empty_top", ras_if.top_addr, 16'h0066);
        check("pp_empty_unf", ras_if.underflow, 1);
        op(0, 1, 16'h0, 1);
        check("pp_empty_clr", ras_if.underflow, 0);

        // fill, overflow, drain
        for (int i = 0; i < 8; i++) op(1, 0, 16'h1000 + 16'(i), 0);
        check("t2_full", ras_if.full, 1);
        check("t2_top", ras_if.top_addr, 16'h1007);
        op(1, 0, 16'h2000, 0);
        check("t2_ovf", ras_if.overflow, 1);
        check("t2_count", ras_if.count, 8);
        check("t2_full_after", ras_if.full, 1);
`ifdef RAS_WRAP_EN
        check("t2_top_wrap", ras_if.top_addr, 16'h2000);
`else
        check("t2_top_drop", ras_if.top_addr, 16'h1007);
`endif
        op(0, 0, 16'h0, 1);
        check("t2_ovf_clr", ras_if.overflow, 0);
        for (int i = 0; i < 8; i++) begin
`ifdef RAS_WRAP_EN
            exp_top = (i == 0) ? 16'h2000 : 16'h1008 - 16'(i);
`else
            exp_top = 16'h1007 - 16'(i);
`endif
            check($sformatf("t6_lifo%0d", i), ras_if.top_addr, exp_top);
            op(0, 1, 16'h0, 0);
        end
        check("t6_empty", ras_if.empty, 1);
        check("t6_top", ras_if.top_addr, 0);
        check("t6_no_unf", ras_if.underflow, 0);

        // async reset mid-cycle with flags set
        op(0, 1, 16'h0, 0);
        op(1, 0, 16'h000A, 0);
        op(1, 0, 16'h000B, 0);
        op(1, 0, 16'h000C, 0);
        check("t5_pre_count", ras_if.count, 3);
        check("t5_pre_unf", ras_if.underflow, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_async_empty", ras_if.empty, 1);
        check("t5_async_count", ras_if.count, 0);
        check("t5_async_top", ras_if.top_addr, 0);
        check("t5_async_unf", ras_if.underflow, 0);
        op(1, 0, 16'h00EE, 0);
        check("t5_push_ignored", ras_if.count, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_post_empty", ras_if.empty, 1);
        op(1, 0, 16'h0077, 0);
        check("t5_resume_top", ras_if.top_addr, 16'h0077);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Hardware return-address stack (LIFO) for the 16-bit RISC CPU.
- On CALL, the control unit pushes the return address (PC+1); on RET, it pops, and top_addr drives the PC's load data so the PC loads it.
- It is the producer side of the PC load-data path; it supplies the address the PC consumes when ld is asserted.

Parameters:
- AW, 16, address width in bits.
- DEPTH, 8, number of entries; must be a power of two, >= 2.
- CW, $clog2(DEPTH+1), width of count (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears pointer, count and flags.
- push  in  1  push push_addr this cycle (CALL).
- pop  in  1  remove top entry this cycle (RET).
- push_addr  in  AW  return address to store.
- clr_err  in  1  synchronous clear of sticky error flags.
- top_addr  out  AW  current top entry; 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  CW  number of valid entries.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (asynchronous, active-high):
  - count=0, sp=0, overflow=0, underflow=0.
  - top_addr=0, empty=1, full=0.
  - Storage array contents are don't-care; they are not reset.
- All state updates on posedge clk; operations take effect next cycle.
- top_addr, empty and full are combinational from registered state, so pop latency to the PC is 0. The PC samples top_addr in the same cycle pop=1 and ld=1.
- push only, not full: mem[sp]<=push_addr; sp<=sp+1; count+1.
- pop only, not empty: sp<=sp-1; count-1; the entry is discarded.
- push and pop together, not empty: the top entry is replaced (mem[sp-1]<=push_addr); sp and count unchanged. This is the tail-call case.
- push and pop together, empty: treated as push only, and underflow is set.
- push only, full: write dropped, state unchanged, overflow<=1.
- pop only, empty: state unchanged, underflow<=1, top_addr stays 0.
- Sticky flags:
  - overflow and underflow hold until clr_err or reset.
  - If clr_err is asserted in the same cycle as a new error, the flag is set (set wins).
- Pointer arithmetic is modulo DEPTH (log2(DEPTH) bits).
- count is saturating in the range 0..DEPTH.
- Reset asserted mid-operation overrides any push or pop in that cycle.

Optional Feature:
- Macro: RAS_WRAP_EN.
- Defined (circular mode):
  - A push while full overwrites the oldest entry: mem[sp]<=push_addr; sp<=sp+1.
  - count stays DEPTH and overflow is still set (records a lost frame).
  - A later pop past the wrapped depth returns stale data, as for a standard circular RAS.
- Undefined: a push while full is dropped, as described in Behaviour.

Test Plan:
1. Reset, then push 0x0010, 0x0020, 0x0030 -> count=3, top_addr=0x0030, empty=0; pop -> top_addr=0x0020, count=2.
2. Push 8 addresses 0x1000..0x1007 -> full=1, top_addr=0x1007.
   - Then push 0x2000 -> overflow=1, top_addr=0x1007.
   - With RAS_WRAP_EN: top_addr=0x2000, count=8.
3. From empty, pop -> underflow=1, count=0, top_addr=0x0000.
   - Then clr_err -> underflow=0.
   - clr_err together with a new pop -> underflow stays 1.
4. With count=2, top=0x0044: push=1, pop=1, push_addr=0x0055 -> count=2, top_addr=0x0055; pop -> previous entry returned.
5. With count=3, assert reset asynchronously between clock edges -> immediately empty=1, count=0, top_addr=0, flags cleared; a push coincident with the reset edge is ignored.
6. Fill to 8, drain to 0 with 8 pops -> LIFO order 0x1007..0x1000; empty=1 after the last pop; no underflow.
